bp_node_hidden_delta: RTL and testbench

- Computes the back-propagated error term (delta) of one hidden-layer node: delta = ReLU'(z) * sum_{k=0..NUM_NEXT-1}(w_k * delta_k), in IEEE-754 single precision.
- Sits directly upstream of the per-weight update stage: its o_delta feeds that stage's delta input for every incoming weight of this node.
- Inputs are consumed serially, one (weight, next-layer delta) pair per accepted beat.

---
 rtl/fp32_pkg.sv | 48 ++++
 rtl/fp32_mul_add.sv | 76 +++++++
 rtl/bp_node_hidden_delta.sv | 76 +++++++
 tb/tb_bp_node_hidden_delta.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// fp32_pkg: FP32 constants, field widths, FSM encoding and rounding/packing helpers
// shared by the hidden-delta node and the weight-update stage.
package fp32_pkg;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int BIAS = 127;
   localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
   localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
   localparam logic [31:0] FP_NEG_INF = 32'hFF80_0000;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL = 2'd1;
   localparam logic [1:0] ST_ADD = 2'd2;
   localparam logic [1:0] ST_ACT = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      MUL = ST_MUL,
      ADD = ST_ADD,
      ACT = ST_ACT
   } state_t;

   function automatic logic [31:0] fp_inf(input logic s);
      return s ? FP_NEG_INF : FP_POS_INF;
   endfunction

   function automatic logic [31:0] fp_zero(input logic s);
      return {s, 31'h0};
   endfunction

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      n = 5'd0;
      for (int i = 0; i < 27; i++)
         if (v[i]) n = 5'(26 - i);
      return n;
   endfunction

   // m carries the hidden bit; rounds to nearest-even, then saturates or flushes
   function automatic logic [31:0] fp_pack(input logic s, input logic signed [9:0] e,
                                           input logic [23:0] m, input logic g, input logic st);
      logic [24:0] r;
      logic signed [9:0] ef;
      r = {1'b0, m} + 25'(g & (st | m[0]));
      ef = r[24] ? e + 10'sd1 : e;
      return (ef >= 10'sd255) ? fp_inf(s) : (ef <= 10'sd0) ? fp_zero(s) : {s, ef[7:0], r[22:0]};
   endfunction
endpackage

// File: rtl/fp32_mul_add.sv
// fp32_mul_add: combinational FP32 multiplier and adder, round-to-nearest-even,
// denormals flushed to signed zero, overflow saturating to infinity, quiet-NaN out.
module fp32_mul_add
   import fp32_pkg::*;
(
   input  logic [31:0] mul_a,
   input  logic [31:0] mul_b,
   input  logic [31:0] add_a,
   input  logic [31:0] add_b,
   output logic [31:0] prod,
   output logic [31:0] sum
);
   logic ma_s, mb_s, ps;
   logic [7:0] ma_e, mb_e;
   logic [22:0] ma_f, mb_f;
   logic ma_nan, mb_nan, ma_inf, mb_inf, ma_zero, mb_zero;
   logic [47:0] p;
   logic signed [9:0] pe;
   logic [23:0] pm;
   logic pg, pst;

   assign {ma_s, ma_e, ma_f} = mul_a;
   assign {mb_s, mb_e, mb_f} = mul_b;
   assign ma_nan = ma_e == 8'hFF && ma_f != 23'h0;
   assign mb_nan = mb_e == 8'hFF && mb_f != 23'h0;
   assign ma_inf = ma_e == 8'hFF && ma_f == 23'h0;
   assign mb_inf = mb_e == 8'hFF && mb_f == 23'h0;
   assign ma_zero = ma_e == 8'h00;
   assign mb_zero = mb_e == 8'h00;
   assign ps = ma_s ^ mb_s;
   assign p = {1'b1, ma_f} * {1'b1, mb_f};
   assign pe = $signed({2'b0, ma_e}) + $signed({2'b0, mb_e}) - 10'(BIAS) + (p[47] ? 10'sd1 : 10'sd0);
   assign pm = p[47] ? p[47:24] : p[46:23];
   assign pg = p[47] ? p[23] : p[22];
   assign pst = p[47] ? |p[22:0] : |p[21:0];
   assign prod = (ma_nan || mb_nan || (ma_inf && mb_zero) || (mb_inf && ma_zero)) ? FP_QNAN :
                 (ma_inf || mb_inf) ? fp_inf(ps) :
                 (ma_zero || mb_zero) ? fp_zero(ps) : fp_pack(ps, pe, pm, pg, pst);

   logic xs, ys, ls, ss, swap;
   logic [7:0] xe, ye, le, se;
   logic [22:0] xf, yf, lf, sf;
   logic x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
   logic [49:0] sh;
   logic [26:0] lx, sx, n;
   logic [27:0] s28;
   logic [4:0] lz;
   logic signed [9:0] ne;

   assign {xs, xe, xf} = add_a;
   assign {ys, ye, yf} = add_b;
   assign x_nan = xe == 8'hFF && xf != 23'h0;
   assign y_nan = ye == 8'hFF && yf != 23'h0;
   assign x_inf = xe == 8'hFF && xf == 23'h0;
   assign y_inf = ye == 8'hFF && yf == 23'h0;
   assign x_zero = xe == 8'h00;
   assign y_zero = ye == 8'h00;
   // order by magnitude so the aligned difference is never negative
   assign swap = {ye, yf} > {xe, xf};
   assign {ls, le, lf} = swap ? add_b : add_a;
   assign {ss, se, sf} = swap ? add_a : add_b;
   assign sh = {1'b1, sf, 26'h0} >> (le - se);
   assign sx = {sh[49:24], |sh[23:0]};
   assign lx = {1'b1, lf, 3'b000};
   assign s28 = (ls ^ ss) ? {1'b0, lx} - {1'b0, sx} : {1'b0, lx} + {1'b0, sx};
   assign lz = lzc27(s28[26:0]);
   assign n = s28[27] ? {s28[27:2], s28[1] | s28[0]} : s28[26:0] << lz;
   assign ne = $signed({2'b0, le}) + (s28[27] ? 10'sd1 : -$signed({5'd0, lz}));
   assign sum = (x_nan || y_nan || (x_inf && y_inf && xs != ys)) ? FP_QNAN :
                x_inf ? fp_inf(xs) :
                y_inf ? fp_inf(ys) :
                (x_zero && y_zero) ? fp_zero(xs & ys) :
                x_zero ? add_b :
                y_zero ? add_a :
                (s28 == 28'h0) ? FP_POS_ZERO : fp_pack(ls, ne, n[26:3], n[2], |n[1:0]);
endmodule

// File: rtl/bp_node_hidden_delta.sv
// bp_node_hidden_delta: serial hidden-node back-prop delta,
// delta = ReLU'(z) * sum(w_k * delta_k), one pair accepted every three cycles.
module bp_node_hidden_delta
   import fp32_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_NEXT = 4,
   parameter int CNT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_weight,
   input  logic [DATA_WIDTH-1:0] i_delta,
   input  logic [DATA_WIDTH-1:0] i_z,
   output logic                  o_ready,
   output logic [DATA_WIDTH-1:0] o_delta,
   output logic                  o_valid
);
   state_t state, nxt;
   logic [CNT_WIDTH-1:0] cnt;
   logic [31:0] w_r, d_r, z_r, prod_r, acc, prod, sum;
   logic accept, last, z_pos;

   fp32_mul_add u_fp (
      .mul_a(w_r),
      .mul_b(d_r),
      .add_a(acc),
      .add_b(prod_r),
      .prod (prod),
      .sum  (sum)
   );

   assign o_ready = state == IDLE && !rst_n;
   assign o_valid = state == ACT;
   assign accept = i_valid && o_ready;
   assign last = cnt == CNT_WIDTH'(NUM_NEXT - 1);
   // NaN and zero/denormal z both fall outside the positive branch
   assign z_pos = !z_r[31] && z_r[30:23] != 8'h00 && !(z_r[30:23] == 8'hFF && z_r[22:0] != 23'h0);

   always_comb begin
      nxt = state;
      nxt = (state == IDLE) ? (accept ? MUL : IDLE) :
            (state == MUL) ? ADD :
            (state == ADD) ? (last ? ACT : IDLE) : IDLE;
   end

   always_ff @(posedge clk or posedge rst_n)
      if (rst_n) begin
         state <= IDLE;
         cnt <= '0;
         w_r <= FP_POS_ZERO;
         d_r <= FP_POS_ZERO;
         z_r <= FP_POS_ZERO;
         prod_r <= FP_POS_ZERO;
         acc <= FP_POS_ZERO;
         o_delta <= FP_POS_ZERO;
      end else begin
         state <= nxt;
         if (accept) begin
            w_r <= i_weight;
            d_r <= i_delta;
            if (cnt == '0) begin
               z_r <= i_z;
               acc <= FP_POS_ZERO;
            end
         end
         if (state == MUL) prod_r <= prod;
         if (state == ADD) begin
            acc <= sum;
            if (last) o_delta <= z_pos ? sum : FP_POS_ZERO;
            else cnt <= cnt + CNT_WIDTH'(1);
         end
         if (state == ACT) cnt <= '0;
      end
endmodule

// File: tb/tb_bp_node_hidden_delta.sv
// tb_bp_node_hidden_delta: directed vectors with hand-computed FP32 results for a
// 4-input and a 2-input node instance.
module tb_bp_node_hidden_delta;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic v4, v2, sel;
   logic [31:0] w, d, z;
   logic rdy4, rdy2, val4, val2;
   logic [31:0] od4, od2;
   logic cur_rdy, cur_val;
   logic [31:0] cur_od;
   logic [31:0] pw[4], pd[4];
   int checks = 0, errors = 0, pulses4 = 0, pulses2 = 0;

   always #5 clk = ~clk;

   bp_node_hidden_delta #(.DATA_WIDTH(32), .NUM_NEXT(4), .CNT_WIDTH(8)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .i_valid(v4), .i_weight(w), .i_delta(d), .i_z(z),
      .o_ready(rdy4), .o_delta(od4), .o_valid(val4)
   );

   bp_node_hidden_delta #(.DATA_WIDTH(32), .NUM_NEXT(2), .CNT_WIDTH(8)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .i_valid(v2), .i_weight(w), .i_delta(d), .i_z(z),
      .o_ready(rdy2), .o_delta(od2), .o_valid(val2)
   );

   assign cur_rdy = sel ? rdy2 : rdy4;
   assign cur_val = sel ? val2 : val4;
   assign cur_od = sel ? od2 : od4;

   always @(posedge clk) begin
      if (val4) pulses4++;
      if (val2) pulses2++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input int idx, input logic [31:0] zz);
      int n = 0;
      while (!cur_rdy && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("ready_wait", {31'h0, cur_rdy}, 32'h1);
      w = pw[idx];
      d = pd[idx];
      z = (idx == 0) ? zz : $urandom;
      if (sel) v2 = 1'b1;
      else v4 = 1'b1;
      @(posedge clk);
      #1;
      v2 = 1'b0;
      v4 = 1'b0;
      z = $urandom;
   endtask

   task automatic tail(input string tag, input logic [31:0] exp, input int p0);
      check({tag, "_mul_v"}, {31'h0, cur_val}, 32'h0);
      @(posedge clk);
      #1;
      check({tag, "_add_v"}, {31'h0, cur_val}, 32'h0);
      @(posedge clk);
      #1;
      check({tag, "_act_v"}, {31'h0, cur_val}, 32'h1);
      check({tag, "_delta"}, cur_od, exp);
      @(posedge clk);
      #1;
      check({tag, "_v_drop"}, {31'h0, cur_val}, 32'h0);
      check({tag, "_hold"}, cur_od, exp);
      check({tag, "_pulses"}, (sel ? pulses2 : pulses4) - p0, 32'd1);
   endtask

   task automatic run(input int n, input logic [31:0] zz, input logic [31:0] exp, input string tag);
      int p0 = sel ? pulses2 : pulses4;
      for (int i = 0; i < n; i++) send(i, zz);
      tail(tag, exp, p0);
   endtask

   task automatic stream(input logic [31:0] zz, input logic [31:0] exp);
      int idx = 0, cyc = 0, p0 = pulses4;
      logic r;
      v4 = 1'b1;
      while (idx < 4 && cyc < 40) begin
         r = rdy4;
         w = r ? pw[idx] : $urandom;
         d = r ? pd[idx] : $urandom;
         z = (r && idx == 0) ? zz : $urandom;
         if (cyc < 10) check("hs_ready", {31'h0, r}, {31'h0, cyc % 3 == 0});
         @(posedge clk);
         #1;
         if (r) idx++;
         cyc++;
      end
      v4 = 1'b0;
      check("hs_accepts", idx, 32'd4);
      tail("hs", exp, p0);
   endtask

   task automatic set2(input logic [31:0] w0, d0, w1, d1);
      pw[0] = w0; pd[0] = d0; pw[1] = w1; pd[1] = d1;
   endtask

   initial begin
      int p;
      v4 = 1'b0; v2 = 1'b0; sel = 1'b0;
      w = '0; d = '0; z = '0;
      #2;
      check("rst_ready", {31'h0, rdy4}, 32'h0);
      check("rst_valid", {31'h0, val4}, 32'h0);
      check("rst_delta", od4, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("idle_ready", {31'h0, rdy4}, 32'h1);
      pw[0] = 32'h4000_0000; pd[0] = 32'h3F00_0000;
      pw[1] = 32'h3FC0_0000; pd[1] = 32'hBF80_0000;
      pw[2] = 32'h3F80_0000; pd[2] = 32'h3F80_0000;
      pw[3] = 32'h4000_0000; pd[3] = 32'hBF00_0000;
      run(4, 32'h3F80_0000, 32'hBF00_0000, "nominal");
      run(4, 32'hC093_3333, 32'h0000_0000, "neg_z");
      run(4, 32'h3F80_0000, 32'hBF00_0000, "renominal");
      run(4, 32'h0000_0000, 32'h0000_0000, "pzero_z");
      run(4, 32'h8000_0000, 32'h0000_0000, "nzero_z");
      stream(32'h3F80_0000, 32'hBF00_0000);
      p = pulses4;
      send(0, 32'h3F80_0000);
      send(1, 32'h3F80_0000);
      #2;
      rst_n = 1'b1;
      #1;
      check("abort_ready", {31'h0, rdy4}, 32'h0);
      check("abort_valid", {31'h0, val4}, 32'h0);
      check("abort_delta", od4, 32'h0);
      #2;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("abort_pulses", pulses4 - p, 32'd0);
      run(4, 32'h3F80_0000, 32'hBF00_0000, "after_abort");
      sel = 1'b1;
      set2(32'h4000_0000, 32'h3F80_0000, 32'hC000_0000, 32'h3F80_0000);
      run(2, 32'h3F80_0000, 32'h0000_0000, "cancel");
      set2(32'h3F80_0000, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
      run(2, 32'h3F80_0000, 32'h3F80_0000, "rne_even");
      set2(32'h3F80_0001, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
      run(2, 32'h3F80_0000, 32'h3F80_0002, "rne_odd");
      set2(32'h3F80_0001, 32'h3F80_0001, 32'h0000_0000, 32'h0000_0000);
      run(2, 32'h3F80_0000, 32'h3F80_0002, "mul_round");
      set2(32'h7F00_0000, 32'h7F00_0000, 32'h3F80_0000, 32'h3F80_0000);
      run(2, 32'h3F80_0000, 32'h7F80_0000, "overflow");
      set2(32'h7F80_0001, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
      run(2, 32'h3F80_0000, 32'h7FC0_0000, "nan_in");
      set2(32'h7F80_0000, 32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000);
      run(2, 32'h3F80_0000, 32'h7FC0_0000, "inf_x_zero");
      set2(32'h1F80_0000, 32'h1F80_0000, 32'hBF80_0000, 32'h0040_0000);
      run(2, 32'h3F80_0000, 32'h0000_0000, "flush");
      set2(32'h3F80_0000, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
      run(2, 32'h7FC0_0000, 32'h0000_0000, "nan_z");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end
endmodule
